// File: rtl/pipe_stage_elastic.sv
// Elastic multi-stage pipeline register with a valid/ready handshake.
// DEPTH register stages move a packed payload toward the output. Empty stages
// always load, so bubbles collapse while the output is stalled. A synchronous
// flush empties every stage, and a saturating counter records the cycles in
// which downstream was ready but no entry was available.
module pipe_stage_elastic #(
   parameter int unsigned       DATA_W  = 8,
   parameter int unsigned       DEPTH   = 2,
   parameter logic [DATA_W-1:0] CLR_VAL = '0,
   parameter int unsigned       CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]           bubble_cnt
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0]  stageValid;
   logic [DATA_W-1:0] stageData [DEPTH];
   logic [DEPTH-1:0]  stageEn;
   logic [DEPTH-1:0]  srcValid;
   logic [DATA_W-1:0] srcData [DEPTH];
   logic              bubbleInc;

   // Enable chain from the output backward: a stage may load if it is empty
   // or the stage after it is moving.
   always_comb begin
      logic chain;
      stageEn = '0;
      chain   = !stageValid[DEPTH-1] || out_ready;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         stageEn[DEPTH-1-i] = chain;
         if (i + 1 < DEPTH) begin
            chain = !stageValid[DEPTH-2-i] || chain;
         end
      end
   end

   // Source of each stage: the upstream port for stage 0, else the previous stage.
   always_comb begin
      srcValid    = '0;
      srcValid[0] = in_valid;
      srcData[0]  = in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         srcValid[k] = stageValid[k-1];
         srcData[k]  = stageData[k-1];
      end
   end

   // Stage registers: flush empties everything, otherwise enabled stages load
   // their source and empty slots carry CLR_VAL so inactive controls read clean.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stageValid <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            stageData[k] <= CLR_VAL;
         end
      end else if (flush) begin
         stageValid <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            stageData[k] <= CLR_VAL;
         end
      end else begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (stageEn[k]) begin
               stageValid[k] <= srcValid[k];
               stageData[k]  <= srcValid[k] ? srcData[k] : CLR_VAL;
            end
         end
      end
   end

   // Handshake outputs; flush blocks both transfers in its own cycle.
   always_comb begin
      in_ready  = stageEn[0] && !flush;
      out_valid = stageValid[DEPTH-1] && !flush;
      out_data  = stageData[DEPTH-1];
   end

   // Occupancy is the population count of the registered valid bits.
   always_comb begin
      occupancy = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         occupancy = occupancy + OCC_W'(stageValid[k]);
      end
   end

   assign bubbleInc = out_ready && !out_valid && !flush;

   // Saturating bubble counter, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt <= '0;
      end else if (bubbleInc && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised, elastic multi-stage pipeline register for control/data bundles between pipeline stages (e.g. MEM->WB control fields packed into one vector). Replaces fixed single-stage registers with DEPTH stages and a valid/ready handshake. Bubbles collapse when downstream stalls. Includes synchronous flush and a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 8, width of packed payload (e.g. {RegWrite, ResultSrc[1:0], ...})
DEPTH, 2, number of register stages, legal range 1..8
CLR_VAL, {DATA_W{1'b0}}, payload value held by empty/flushed/reset stages (control signals inactive)
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
flush  input  1  synchronous kill of all in-flight entries
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage 0 can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  last stage holds valid entry
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  last-stage payload
occupancy  output  $clog2(DEPTH+1)  count of valid stages
bubble_cnt  output  CNT_W  cycles with out_ready=1 and out_valid=0, saturating

Behaviour:
- State: v[k], d[k] for k=0..DEPTH-1; stage DEPTH-1 drives outputs.
- Reset (async): all v=0, all d=CLR_VAL, bubble_cnt=0. Thus out_valid=0, out_data=CLR_VAL, occupancy=0, in_ready=1 once reset deasserts (0 while flush=1).
- Enable chain (combinational): en[DEPTH-1] = !v[DEPTH-1] || out_ready; en[k] = !v[k] || en[k+1] for k<DEPTH-1.
- On edge with en[k]=1 and flush=0: v[k] <= src_v; d[k] <= src_v ? src_d : CLR_VAL. For k=0, src = (in_valid, in_data); else src = (v[k-1], d[k-1]). Stage with en[k]=0 holds.
- Bubble collapse: an empty stage always loads even when downstream is stalled, so no valid entry ever waits behind an empty stage.
- in_ready = en[0] && !flush; out_valid = v[DEPTH-1] && !flush; out_data = d[DEPTH-1], equal to CLR_VAL whenever v[DEPTH-1]=0.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready. No entry is dropped or duplicated except by flush.
- Latency: with out_ready held 1 and the pipe empty, an entry accepted at edge t appears with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles input-to-output. Throughput: 1 entry/cycle sustained.
- Full: all v=1 and out_ready=0 -> in_ready=0, all stages hold.
- Flush: on the edge, all v<=0 and d<=CLR_VAL. The input is not accepted and there is no output transfer in the flush cycle. Flush has priority over every handshake.
- Flush+reset: reset dominates asynchronously.
- occupancy = popcount(v), registered-state based, unaffected combinationally by flush.
- bubble_cnt: increments on the edge when out_ready=1, out_valid=0 and flush=0. Holds at 2^CNT_W-1. Cleared only by reset.
- Reset mid-operation: all in-flight entries are lost immediately. Outputs take reset values asynchronously.
- DEPTH=1: behaves as a single handshaked register with the same flush/bubble rules.

Test Plan:
- Reset: assert reset mid-stream with 2 entries valid -> out_valid=0, out_data=CLR_VAL, occupancy=0, bubble_cnt=0 immediately, before any clock edge.
- Streaming, DEPTH=2, out_ready=1: push 0x11, 0x22, 0x33 on consecutive cycles -> outputs 0x11, 0x22, 0x33 on consecutive cycles, first one 2 cycles after its input. in_ready stays 1.
- Backpressure/full, DEPTH=3: out_ready=0, push 4 entries -> 3 accepted, then in_ready=0 and occupancy=3. Raise out_ready -> 0xA1, 0xA2, 0xA3 emitted in order with no loss.
- Bubble collapse, DEPTH=3: entry 0x5 in stage 2 with stage 1 empty, out_ready=0; push 0x6 -> 0x6 advances into stage 1 next cycle, occupancy=2.
- Flush: pipe holding 0x7, 0x8 with in_valid=1 and out_ready=1, pulse flush 1 cycle -> no output transfer and no input accept that cycle. Next cycle occupancy=0 and out_data=CLR_VAL.
- Bubble counter, CNT_W=2: out_ready=1, pipe empty for 5 cycles -> bubble_cnt 1, 2, 3, 3, 3. A flush cycle does not increment it.
